// File: rtl/spi_lce_rx_guard_if.sv
// spi_lce_rx_guard_if: raw SPI pins in, recovered lce word and link status out.
// master = pin driver / word consumer, slave = the receive guard.
interface spi_lce_rx_guard_if;
    logic        sck_pin;
    logic        ssel_pin;
    logic        data_pin;
    logic [31:0] word_out;
    logic        word_valid;
    logic        frame_err;
    logic [15:0] err_cnt;
    logic        stale;

    modport master (
        output sck_pin, ssel_pin, data_pin,
        input  word_out, word_valid, frame_err, err_cnt, stale
    );

    modport slave (
        input  sck_pin, ssel_pin, data_pin,
        output word_out, word_valid, frame_err, err_cnt, stale
    );
endinterface

// File: rtl/spi_lce_rx_guard.sv
// spi_lce_rx_guard: oversampling SPI receiver that holds the last good lce word.
// Optional macro SPI_RX_FLOAT_CHECK_EN rejects Inf/NaN frames.
module spi_lce_rx_guard #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter logic [31:0] RESET_WORD     = 32'h0000_0000,
    parameter int          FRAME_BITS     = 32
) (
    input logic              clk,
    input logic              reset,
    spi_lce_rx_guard_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [5:0] FRAME_LEN = 6'(FRAME_BITS);

    logic [2:0]  sck_sync;
    logic [2:0]  ssel_sync;
    logic [1:0]  data_sync;
    logic        sck_rise;
    logic        ssel_fall;
    logic        ssel_rise;
    logic        data;

    logic [1:0]  warm;
    logic        armed;

    logic [1:0]  state;
    logic [5:0]  bit_cnt;
    logic [31:0] shreg;
    logic        frame_ok;
    logic        accept;

    logic [31:0] word_q;
    logic        valid_q;
    logic        err_q;
    logic [15:0] err_cnt_q;

    logic [23:0] wd_cnt;
    logic [23:0] wd_cnt_d;
    logic        stale_q;

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign ssel_fall = ~ssel_sync[1] & ssel_sync[2];
    assign ssel_rise = ssel_sync[1] & ~ssel_sync[2];
    assign data      = data_sync[1];

`ifdef SPI_RX_FLOAT_CHECK_EN
    assign frame_ok = (bit_cnt == FRAME_LEN) && (shreg[30:23] != 8'hFF);
`else
    assign frame_ok = (bit_cnt == FRAME_LEN);
`endif

    assign accept = (state == ST_CHECK) && frame_ok;

    // Resample the asynchronous pins; reset to the idle bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= 3'b111;
            ssel_sync <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            sck_sync  <= {sck_sync[1:0], bus.sck_pin};
            ssel_sync <= {ssel_sync[1:0], bus.ssel_pin};
            data_sync <= {data_sync[0], bus.data_pin};
        end
    end

    // Arm only after a real (non-reset) high SSEL, so a frame cut by reset is skipped.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1] && ssel_sync[1]) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame FSM: collect bits while SSEL is low, judge the frame for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 6'd0;
            shreg     <= 32'd0;
            word_q    <= RESET_WORD;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ssel_fall && armed) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= 6'd0;
                        shreg   <= 32'd0;
                    end
                end
                ST_SHIFT: begin
                    if (ssel_rise) begin
                        state <= ST_CHECK;
                    end else if (sck_rise) begin
                        shreg <= {shreg[30:0], data};
                        if (bit_cnt != 6'h3F) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        word_q  <= shreg;
                        valid_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                    end
                    if (!ssel_sync[1]) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= 6'd0;
                        shreg   <= 32'd0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Watchdog restarts on the edge that raises word_valid; stale follows its next value.
    always_comb begin
        wd_cnt_d = wd_cnt;
        if (accept) begin
            wd_cnt_d = 24'd0;
        end else if (wd_cnt != TIMEOUT_CYCLES) begin
            wd_cnt_d = wd_cnt + 24'd1;
        end
    end

    // Stale flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt  <= TIMEOUT_CYCLES;
            stale_q <= 1'b1;
        end else begin
            wd_cnt  <= wd_cnt_d;
            stale_q <= (wd_cnt_d == TIMEOUT_CYCLES);
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.stale      = stale_q;

endmodule

// File: doc/spi_lce_rx_guard.md
Name: spi_lce_rx_guard

Overview:
- Oversampling SPI receive front-end for the board-to-board link. It recovers 32-bit muscle-length words (IEEE-754 single) sent by the peer board's SPI master.
- Rejects malformed frames and holds the last good word for the spindle `lce` input.
- Flags a stale link when frames stop arriving.
- Sits between the JP1 input pins and the `sim_clk` resampling register that feeds the spindle.

Parameters:
- `TIMEOUT_CYCLES`, 24'd1_000_000: clk cycles without a good frame before `stale` asserts.
- `RESET_WORD`, 32'h0000_0000: value of `word_out` after reset.
- `FRAME_BITS`, 32: required SCK rising edges per frame.

Ports:
- `clk`  in  1  system clock (`clk1`).
- `reset`  in  1  synchronous, active-high reset.
- `sck_pin`  in  1  raw SPI clock from peer (asynchronous).
- `ssel_pin`  in  1  raw SPI select, active low (asynchronous).
- `data_pin`  in  1  raw SPI data, MSB first (asynchronous).
- `word_out`  out  32  last accepted word, held between frames.
- `word_valid`  out  1  one-cycle pulse when `word_out` updates.
- `frame_err`  out  1  one-cycle pulse on a rejected frame.
- `err_cnt`  out  16  rejected-frame count, saturates at 16'hFFFF.
- `stale`  out  1  high when no good frame has arrived for `TIMEOUT_CYCLES`.

Behaviour:
- Sync and edge detect:
  - Each pin passes through a 2-FF synchronizer (s1, s2), plus a third register s3 for edge detection.
  - `sck_rise` = s2 & ~s3.
  - `ssel_fall` = ~s2 & s3.
  - `ssel_rise` = s2 & ~s3.
  - `data` is taken from s2 of the data synchronizer.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: on `ssel_fall` go to SHIFT; clear `bit_cnt` and `shreg`.
  - SHIFT:
    - On `sck_rise`: `shreg` <= {`shreg`[30:0], data}; `bit_cnt` increments. `bit_cnt` is 6 bits and saturates at 63.
    - On `ssel_rise`: go to CHECK.
    - If `ssel_rise` and `sck_rise` occur in the same cycle, `ssel_rise` wins and the SCK edge is ignored.
  - CHECK (exactly one cycle):
    - If `bit_cnt` == `FRAME_BITS` (and the optional check passes): `word_out` <= `shreg`, pulse `word_valid`.
    - Otherwise: pulse `frame_err`; `err_cnt` increments (saturating); `word_out` is unchanged.
    - Next state: SHIFT (with `bit_cnt`/`shreg` cleared) if synced SSEL is already low, else IDLE.
- Latency: `word_valid` is high in the 4th clk cycle after the first clk edge that samples `ssel_pin` high. No output reacts combinationally to the pins.
- Stale watchdog:
  - 24-bit counter, cleared on every `word_valid`; otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - `stale` = (counter == `TIMEOUT_CYCLES`), registered.
  - A `frame_err` does not clear the counter.
- Reset values: `word_out`=`RESET_WORD`, `word_valid`=0, `frame_err`=0, `err_cnt`=0, `stale`=1, counter=`TIMEOUT_CYCLES`, FSM=IDLE, synchronizers=1 (idle bus level).
- Reset mid-frame: the partial frame is discarded with no `frame_err` pulse. After reset, the FSM waits in IDLE for a fresh `ssel_fall`; if SSEL is still low, no frame is accepted until SSEL goes high and low again.
- SCK edges while in IDLE are ignored.

Optional Feature:
- Macro: `SPI_RX_FLOAT_CHECK_EN`.
- Defined: in CHECK, a 32-bit frame whose exponent field `shreg`[30:23] == 8'hFF (Inf/NaN) is rejected. It is treated exactly as a length error: `frame_err` pulses, `err_cnt` increments, `word_out` holds.
- Undefined: any 32-bit frame is accepted regardless of content.

Test Plan:
- Reset check: reset, then release → `word_out`=0, `stale`=1, `err_cnt`=0, no pulses.
- Good frame: send 32'h3F80_0000 (SCK period 26 clk, SSEL low for 32 bits) → `word_valid` one pulse exactly 4 cycles after SSEL pin rise, `word_out`=32'h3F80_0000, `stale`=0 on the following cycle.
- Short and long frames:
  - 31-bit frame after the good frame → `frame_err` pulse, `err_cnt`=1, `word_out` stays 32'h3F80_0000.
  - 33-bit frame → `err_cnt`=2.
- Watchdog timing with `TIMEOUT_CYCLES`=100: after a good frame, send nothing → `stale` rises exactly 100 cycles after the `word_valid` cycle. A further good frame clears it.
- Back-to-back and reset abort:
  - Two frames with SSEL high for 1 clk between them → both accepted, `word_out` = second word.
  - Assert `reset` at bit 16 of a frame → no `frame_err`, `word_out`=0, next complete frame accepted.
- `SPI_RX_FLOAT_CHECK_EN` defined: send 32'h7FC0_0000 → `frame_err`, `word_out` unchanged. Undefined: same stimulus → accepted.
